// File: rtl/step_ctrl_pkg.sv
// Shared types and default constants for the CPU step controller.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10
  } step_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned STEP_CNT_W_DEF      = 32;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizer, debounce counter and one-cycle press pulse for an active-low button.
// Macro STEP_CTRL_DEBOUNCE_EN enables the counter; otherwise the synchronized level is used directly.
module button_debouncer
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic press
);

`ifdef STEP_CTRL_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_sync;

  // Synchronizer resets to the released level so reset release is not seen as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '1;
    else          sync <= {sync[SYNC_STAGES-2:0], btn_n};
  end

  assign btn_sync = sync[SYNC_STAGES-1];

  // A one-cycle threshold is identical to the bypass path, so it shares it.
  if (DEB_EN && DEBOUNCE_CYCLES > 1) begin : g_debounce
    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             level;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        level <= 1'b1;
        press <= 1'b0;
      end else begin
        press <= 1'b0;
        if (btn_sync == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          level <= btn_sync;
          press <= ~btn_sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end else begin : g_bypass
    logic level;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        level <= 1'b1;
        press <= 1'b0;
      end else begin
        level <= btn_sync;
        press <= level & ~btn_sync;
      end
    end
  end

endmodule

// File: rtl/cpu_step_controller.sv
// Turns the divider tick and board buttons into single-cycle cpu_en pulses with run/pause/step modes.
// Optional macro STEP_CTRL_DEBOUNCE_EN enables button debounce counters (see button_debouncer).
module cpu_step_controller
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned STEP_CNT_W      = STEP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick_src,
  input  logic                  btn_run_n,
  input  logic                  btn_step_n,
  input  logic                  halt_req,
  output logic                  cpu_en,
  output logic [1:0]            mode,
  output logic [STEP_CNT_W-1:0] step_count
);

  step_state_e            state, state_next;
  logic                   en_next;
  logic                   run_press, step_press;
  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   tick_prev, tick_rise;

  // The edge pulse is registered, giving SYNC_STAGES+1 cycles from sampling to the FSM decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_sync <= '0;
      tick_prev <= 1'b0;
      tick_rise <= 1'b0;
    end else begin
      tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_src};
      tick_prev <= tick_sync[SYNC_STAGES-1];
      tick_rise <= tick_sync[SYNC_STAGES-1] & ~tick_prev;
    end
  end

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_run_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_n  (btn_run_n),
    .press  (run_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_step_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_n  (btn_step_n),
    .press  (step_press)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_PAUSE;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      state  <= state_next;
      cpu_en <= en_next;
      if (en_next) step_count <= step_count + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (halt_req && state != ST_PAUSE) begin
      state_next = ST_PAUSE;
    end else begin
      unique case (state)
        ST_PAUSE: begin
          if (run_press)       state_next = ST_RUN;
          else if (step_press) state_next = ST_STEP;
        end
        ST_RUN:   if (run_press) state_next = ST_PAUSE;
        ST_STEP:  state_next = ST_PAUSE;
        default:  state_next = ST_PAUSE;
      endcase
    end
  end

  // Halt in RUN/STEP and a run press in RUN both suppress the pulse in that cycle.
  always_comb begin
    en_next = 1'b0;
    if (!(halt_req && state != ST_PAUSE)) begin
      unique case (state)
        ST_RUN:  en_next = tick_rise & ~run_press;
        ST_STEP: en_next = 1'b1;
        default: en_next = 1'b0;
      endcase
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Self-checking bench for cpu_step_controller: directed table, hand sequences and a random run
// checked cycle by cycle against a history-based reference model.
module tb_cpu_step_controller;

  localparam int S   = 2;
  localparam int DEB = 4;
  localparam int CW  = 4;
`ifdef STEP_CTRL_DEBOUNCE_EN
  localparam int N_EFF = DEB;
`else
  localparam int N_EFF = 1;
`endif
  localparam int C_B = (N_EFF > 1) ? 6 : 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick_src = 1'b0;
  logic          btn_run_n = 1'b1;
  logic          btn_step_n = 1'b1;
  logic          halt_req = 1'b0;
  logic          cpu_en;
  logic [1:0]    mode;
  logic [CW-1:0] step_count;

  cpu_step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (S),
    .STEP_CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_src  (tick_src),
    .btn_run_n (btn_run_n),
    .btn_step_n(btn_step_n),
    .halt_req  (halt_req),
    .cpu_en    (cpu_en),
    .mode      (mode),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int en_seen, mode1_seen, mode2_seen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input histories since reset, debounce as "last N synchronized samples differ".
  bit h_tick[64], h_run[64], h_step[64];
  int m_n, m_mode, m_en, m_count;
  bit lvl_run, lvl_step, pr_run, pr_step;

  function automatic bit hist(input int sel, input int i);
    if (i < 0) return (sel == 0) ? 1'b0 : 1'b1;
    case (sel)
      0:       return h_tick[i % 64];
      1:       return h_run[i % 64];
      default: return h_step[i % 64];
    endcase
  endfunction

  function automatic bit deb_flip(input int sel, input bit lvl, input int m);
    for (int j = 0; j < N_EFF; j++)
      if (hist(sel, m - j - S) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_n = 0; m_mode = 0; m_en = 0; m_count = 0;
    lvl_run = 1'b1; lvl_step = 1'b1; pr_run = 1'b0; pr_step = 1'b0;
  endtask

  task automatic model_step();
    bit tick_ev;
    int nm, en;
    h_tick[m_n % 64] = tick_src;
    h_run[m_n % 64]  = btn_run_n;
    h_step[m_n % 64] = btn_step_n;
    tick_ev = hist(0, m_n - S - 1) && !hist(0, m_n - S - 2);
    nm = m_mode;
    en = 0;
    if (m_mode != 0 && halt_req) nm = 0;
    else if (m_mode == 0) begin
      if (pr_run) nm = 1;
      else if (pr_step) nm = 2;
    end else if (m_mode == 1) begin
      if (pr_run) nm = 0;
      else if (tick_ev) en = 1;
    end else begin
      en = 1;
      nm = 0;
    end
    m_mode = nm;
    m_en = en;
    if (en == 1) m_count = (m_count + 1) % (1 << CW);
    if (deb_flip(1, lvl_run, m_n)) begin lvl_run = !lvl_run; pr_run = !lvl_run; end
    else pr_run = 1'b0;
    if (deb_flip(2, lvl_step, m_n)) begin lvl_step = !lvl_step; pr_step = !lvl_step; end
    else pr_step = 1'b0;
    m_n++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("cpu_en", int'(cpu_en), m_en);
    check("mode", int'(mode), m_mode);
    check("step_count", int'(step_count), m_count);
    en_seen    += int'(cpu_en);
    mode1_seen += (mode == 2'b01) ? 1 : 0;
    mode2_seen += (mode == 2'b10) ? 1 : 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_press();
    btn_run_n = 1'b0; cycles(6);
    btn_run_n = 1'b1; cycles(6);
  endtask

  task automatic tick_pulse();
    tick_src = 1'b1; cycles(4);
    tick_src = 1'b0; cycles(4);
  endtask

  typedef struct {
    bit run_n;
    bit step_n;
    bit tick;
    bit halt;
    int n_cyc;
    int exp_mode;
    int exp_count;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 15, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 15, 0, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 6, -1, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 1, 0};
    for (int i = 0; i < 4; i++) begin
      tbl[5 + 2 * i] = '{1'b1, 1'b1, 1'b1, 1'b0, 8, 1, i + 1};
      tbl[6 + 2 * i] = '{1'b1, 1'b1, 1'b0, 1'b0, 8, 1, i + 1};
    end

    model_reset();
    #23;
    check("reset_cpu_en", int'(cpu_en), 0);
    check("reset_mode", int'(mode), 0);
    check("reset_count", int'(step_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ticks in PAUSE are ignored.
    en_seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick_src = ((i % 40) >= 20);
      cycle();
    end
    tick_src = 1'b0;
    check("pause_ticks_en", en_seen, 0);
    check("pause_ticks_mode", int'(mode), 0);

    foreach (tbl[i]) begin
      btn_run_n  = tbl[i].run_n;
      btn_step_n = tbl[i].step_n;
      tick_src   = tbl[i].tick;
      halt_req   = tbl[i].halt;
      cycles(tbl[i].n_cyc);
      if (tbl[i].exp_mode >= 0) check("tbl_mode", int'(mode), tbl[i].exp_mode);
      check("tbl_count", int'(step_count), tbl[i].exp_count);
    end

    // Fifth tick: pulse exactly SYNC_STAGES+1 edges after first sample.
    tick_src = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("tick_latency", int'(cpu_en), (i == 3) ? 1 : 0);
    end
    tick_src = 1'b0; cycles(4);
    check("five_ticks_count", int'(step_count), 5);

    // Run press and tick rise reach the FSM on the same edge.
    en_seen = 0;
    btn_run_n = 1'b0;
    cycles(N_EFF - 1);
    tick_src = 1'b1;
    cycles(7 - N_EFF);
    btn_run_n = 1'b1;
    cycles(6);
    tick_src = 1'b0; cycles(4);
    check("run_tick_mode", int'(mode), 0);
    check("run_tick_en", en_seen, 0);
    check("run_tick_count", int'(step_count), 5);

    // Single step from PAUSE.
    en_seen = 0; mode2_seen = 0;
    btn_step_n = 1'b0; cycles(6);
    btn_step_n = 1'b1; cycles(10);
    check("step_mode2_cycles", mode2_seen, 1);
    check("step_pulses", en_seen, 1);
    check("step_mode", int'(mode), 0);
    check("step_count", int'(step_count), 6);

    // Short bounce: filtered only when debounce is enabled.
    btn_step_n = 1'b0; cycles(3);
    btn_step_n = 1'b1; cycles(12);
    check("bounce_count", int'(step_count), C_B);
    check("bounce_mode", int'(mode), 0);

    // Halt coincident with a tick rise in RUN.
    run_press();
    check("halt_pre_mode", int'(mode), 1);
    tick_src = 1'b1; cycles(3);
    halt_req = 1'b1; cycle();
    check("halt_tick_en", int'(cpu_en), 0);
    check("halt_tick_mode", int'(mode), 0);
    en_seen = 0; mode1_seen = 0;
    run_press();
    check("halt_run_mode1_cycles", mode1_seen, 1);
    check("halt_run_en", en_seen, 0);
    check("halt_run_mode", int'(mode), 0);
    check("halt_run_count", int'(step_count), C_B);
    halt_req = 1'b0; tick_src = 1'b0; cycles(4);

    // Random stimulus against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) btn_run_n = ~btn_run_n;
      if ($urandom_range(0, 24) == 0) btn_step_n = ~btn_step_n;
      if ($urandom_range(0, 5) == 0) tick_src = ~tick_src;
      halt_req = ($urandom_range(0, 39) == 0);
      cycle();
    end

    #3;
    reset_n = 1'b0;
    #1;
    check("rst1_cpu_en", int'(cpu_en), 0);
    check("rst1_mode", int'(mode), 0);
    check("rst1_count", int'(step_count), 0);
    btn_run_n = 1'b1; btn_step_n = 1'b1; tick_src = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Counter wrap with a 4-bit step_count.
    run_press();
    check("wrap_mode", int'(mode), 1);
    check("wrap_start", int'(step_count), 0);
    for (int i = 0; i < 15; i++) tick_pulse();
    check("wrap_15", int'(step_count), 15);
    tick_pulse();
    check("wrap_0", int'(step_count), 0);
    tick_pulse();
    check("wrap_1", int'(step_count), 1);

    // Asynchronous reset mid-RUN with a tick in flight.
    tick_src = 1'b1; cycles(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst2_cpu_en", int'(cpu_en), 0);
    check("rst2_mode", int'(mode), 0);
    check("rst2_count", int'(step_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    tick_src = 1'b0;
    cycles(10);
    check("post_rst_mode", int'(mode), 0);
    check("post_rst_count", int'(step_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
